// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: upstream traffic source for sram_controller (az_/za_ side).
// Writes addr[15:0]^seed over [START_ADDR..END_ADDR], reads the window back, compares
// the returns in order and reports pass / error count / first failing address / timeout.
// Optional feature macro: SDRAM_TEST_LOOP_EN (continuous looping with a rotating seed).
module sdram_pattern_tester #(
    parameter int unsigned        ADDR_W     = 22,
    parameter int unsigned        DATA_W     = 16,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [ADDR_W-1:0]  END_ADDR   = '1,
    parameter logic [15:0]        SEED       = 16'hA5C3,
    parameter int unsigned        MAX_OUTST  = 4,
    parameter int unsigned        TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              az_cs,
    output logic              az_rd_n,
    output logic              az_wr_n,
    output logic [1:0]        az_be_n,
    output logic [ADDR_W-1:0] az_addr,
    output logic [DATA_W-1:0] az_data,
    input  logic              za_valid,
    input  logic              za_wait,
    input  logic [DATA_W-1:0] za_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);

    localparam int unsigned OUT_W = 4;
    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [OUT_W-1:0]    outstanding, outstanding_d;
    logic [ADDR_W-1:0]   rptr, rptr_d;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
    logic [15:0]         seed_q, seed_d;
    logic                err_seen, err_seen_d;

    logic                az_cs_d, az_rd_n_d, az_wr_n_d, busy_d, done_d, pass_d, timeout_d;
    logic [ADDR_W-1:0]   az_addr_d, first_err_addr_d;
    logic [DATA_W-1:0]   az_data_d;
    logic [15:0]         err_count_d;

    logic                wr_acc, rd_acc, spurious, ret_ok, miscmp;
    logic [OUT_W-1:0]    out_next;
    logic [15:0]         err_next;

    assign az_be_n = 2'b00;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [15:0] s);
        return DATA_W'(16'(a) ^ s);
    endfunction

    // Handshake, return bookkeeping and compare, shared by all states
    always_comb begin
        wr_acc   = !az_wr_n && !za_wait;
        rd_acc   = !az_rd_n && !za_wait;
        spurious = za_valid && (outstanding == '0);
        ret_ok   = za_valid && !spurious;
        miscmp   = ret_ok && (za_data != pattern(rptr, seed_q));
        out_next = outstanding + OUT_W'(rd_acc) - OUT_W'(ret_ok);
        err_next = ((spurious || miscmp) && (err_count != 16'hFFFF)) ?
                   err_count + 16'd1 : err_count;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d          = state;
        outstanding_d    = out_next;
        rptr_d           = ret_ok ? rptr + ADDR_W'(1) : rptr;
        tmo_cnt_d        = tmo_cnt;
        seed_d           = seed_q;
        err_seen_d       = err_seen || miscmp;
        az_cs_d          = az_cs;
        az_rd_n_d        = az_rd_n;
        az_wr_n_d        = az_wr_n;
        az_addr_d        = az_addr;
        az_data_d        = az_data;
        busy_d           = busy;
        done_d           = done;
        pass_d           = pass;
        err_count_d      = err_next;
        first_err_addr_d = (miscmp && !err_seen) ? rptr : first_err_addr;
        timeout_d        = timeout;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d          = S_WRITE;
                    busy_d           = 1'b1;
                    az_cs_d          = 1'b1;
                    az_wr_n_d        = 1'b0;
                    az_addr_d        = START_ADDR;
                    az_data_d        = pattern(START_ADDR, SEED);
                    seed_d           = SEED;
                    rptr_d           = START_ADDR;
                    outstanding_d    = '0;
                    err_count_d      = '0;
                    err_seen_d       = 1'b0;
                    first_err_addr_d = '0;
                    timeout_d        = 1'b0;
                    pass_d           = 1'b0;
                    done_d           = 1'b0;
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    if (az_addr == END_ADDR) begin
                        state_d   = S_READ;
                        az_wr_n_d = 1'b1;
                        az_rd_n_d = 1'b0;
                        az_addr_d = START_ADDR;
                    end else begin
                        az_addr_d = az_addr + ADDR_W'(1);
                        az_data_d = pattern(az_addr + ADDR_W'(1), seed_q);
                    end
                end
            end
            S_READ: begin
                if (rd_acc && (az_addr == END_ADDR)) begin
                    state_d   = S_DRAIN;
                    az_rd_n_d = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    if (rd_acc) begin
                        az_addr_d = az_addr + ADDR_W'(1);
                    end
                    az_rd_n_d = (out_next >= OUT_W'(MAX_OUTST));
                end
            end
            S_DRAIN: begin
                if (out_next == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    az_cs_d = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end else if (za_valid) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    az_cs_d   = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + TMO_W'(1);
                end
            end
            S_DONE: begin
                pass_d = (err_next == '0) && !timeout;
                if (!start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
`ifdef SDRAM_TEST_LOOP_EN
                else if (pass) begin
                    state_d       = S_WRITE;
                    done_d        = 1'b0;
                    busy_d        = 1'b1;
                    az_cs_d       = 1'b1;
                    seed_d        = {seed_q[14:0], seed_q[15]};
                    az_wr_n_d     = 1'b0;
                    az_addr_d     = START_ADDR;
                    az_data_d     = pattern(START_ADDR, {seed_q[14:0], seed_q[15]});
                    rptr_d        = START_ADDR;
                    outstanding_d = '0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            outstanding    <= '0;
            rptr           <= '0;
            tmo_cnt        <= '0;
            seed_q         <= SEED;
            err_seen       <= 1'b0;
            az_cs          <= 1'b0;
            az_rd_n        <= 1'b1;
            az_wr_n        <= 1'b1;
            az_addr        <= '0;
            az_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_d;
            outstanding    <= outstanding_d;
            rptr           <= rptr_d;
            tmo_cnt        <= tmo_cnt_d;
            seed_q         <= seed_d;
            err_seen       <= err_seen_d;
            az_cs          <= az_cs_d;
            az_rd_n        <= az_rd_n_d;
            az_wr_n        <= az_wr_n_d;
            az_addr        <= az_addr_d;
            az_data        <= az_data_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_count_d;
            first_err_addr <= first_err_addr_d;
            timeout        <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester over an 8-word window with a simple controller model.
module tb_sdram_pattern_tester;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        az_cs, az_rd_n, az_wr_n;
    logic [1:0]  az_be_n;
    logic [21:0] az_addr;
    logic [15:0] az_data;
    logic        za_valid = 1'b0;
    logic        za_wait = 1'b0;
    logic [15:0] za_data = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [21:0] first_err_addr;

    int tests_run = 0;
    int tests_failed = 0;

    sdram_pattern_tester #(
        .ADDR_W(22), .DATA_W(16), .START_ADDR(22'd0), .END_ADDR(22'd7),
        .SEED(16'hA5C3), .MAX_OUTST(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .az_cs(az_cs), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n), .az_be_n(az_be_n),
        .az_addr(az_addr), .az_data(az_data),
        .za_valid(za_valid), .za_wait(za_wait), .za_data(za_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Controller model state
    int          cyc = 0;
    logic [15:0] mem [0:7];
    int          wr_cnt [0:7];
    int          rd_cnt [0:7];
    int          stall_addr = -1, stall_left = 0, stall_obs = 0, stable_err = 0;
    int          flip_addr = -1, drop_addr = -1, last_rd_cyc = 0;
    int          rq_addr [$];
    int          rq_due  [$];

    // Ideal controller: optional write stalls, read latency 2, optional bit flip / drop
    always begin
        int a;
        @(posedge clk);
        #1;
        cyc++;
        za_valid = 1'b0;
        za_wait  = 1'b0;
        if (rst) begin
            rq_addr.delete();
            rq_due.delete();
        end else begin
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                a = rq_addr.pop_front();
                void'(rq_due.pop_front());
                if (a != drop_addr) begin
                    za_valid = 1'b1;
                    za_data  = mem[a] ^ ((a == flip_addr) ? 16'h0001 : 16'h0000);
                end
            end
            if (!az_wr_n && int'(az_addr) == stall_addr && stall_left > 0) begin
                za_wait = 1'b1;
                stall_left--;
                stall_obs++;
                if (az_addr != 22'd2 || az_data != 16'hA5C1) stable_err++;
            end
            if (!za_wait && !az_wr_n) begin
                if (int'(az_addr) == stall_addr && az_data != 16'hA5C1) stable_err++;
                mem[az_addr[2:0]] = az_data;
                wr_cnt[az_addr[2:0]]++;
            end
            if (!za_wait && !az_rd_n) begin
                rd_cnt[az_addr[2:0]]++;
                rq_addr.push_back(int'(az_addr[2:0]));
                rq_due.push_back(cyc + 2);
                last_rd_cyc = cyc;
            end
        end
    end

    task automatic reset_model();
        stall_addr = -1; stall_left = 0; stall_obs = 0; stable_err = 0;
        flip_addr = -1; drop_addr = -1;
        for (int i = 0; i < 8; i++) begin
            wr_cnt[i] = 0; rd_cnt[i] = 0; mem[i] = 16'h0000;
        end
    endtask

    task automatic go();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_done: done never rose within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({az_rd_n, az_wr_n} !== 2'b11) begin
            tests_failed++; $display("FAIL reset_req_n: got %b want 11", {az_rd_n, az_wr_n});
        end
        tests_run++;
        if ({az_cs, busy, done, pass, timeout} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000", {az_cs, busy, done, pass, timeout});
        end
        tests_run++;
        if (err_count !== 16'd0 || first_err_addr !== 22'd0 || az_addr !== 22'd0 || az_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_values: err=%h fea=%h addr=%h data=%h want all 0",
                     err_count, first_err_addr, az_addr, az_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d;
        reset_model();
        go();
        tests_run++;
        if (az_wr_n !== 1'b0 || az_addr !== 22'd0 || az_data !== 16'hA5C3 || busy !== 1'b1 || az_cs !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_write: wr_n=%b addr=%h data=%h busy=%b cs=%b want 0/0/a5c3/1/1",
                     az_wr_n, az_addr, az_data, busy, az_cs);
        end
        wait_done(d);
        tests_run++;
        if (pass !== 1'b1 || err_count !== 16'd0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: pass=%b err=%0d to=%b want 1/0/0", pass, err_count, timeout);
        end
        tests_run++;
        if (az_be_n !== 2'b00) begin
            tests_failed++; $display("FAIL be_n: got %b want 00", az_be_n);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp;
            exp = 16'(i) ^ 16'hA5C3;
            tests_run++;
            if (mem[i] !== exp || wr_cnt[i] != 1 || rd_cnt[i] != 1) begin
                tests_failed++;
                $display("FAIL basic_mem[%0d]: data=%h wr=%0d rd=%0d want %h/1/1",
                         i, mem[i], wr_cnt[i], rd_cnt[i], exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wait_stall();
        int d;
        reset_model();
        stall_addr = 2; stall_left = 3;
        go();
        wait_done(d);
        tests_run++;
        if (stall_obs != 3 || stable_err != 0 || wr_cnt[2] != 1) begin
            tests_failed++;
            $display("FAIL wait_stall: stalls=%0d unstable=%0d accepts=%0d want 3/0/1",
                     stall_obs, stable_err, wr_cnt[2]);
        end
        tests_run++;
        if (pass !== 1'b1 || mem[2] !== 16'hA5C1) begin
            tests_failed++; $display("FAIL stall_result: pass=%b mem2=%h want 1/a5c1", pass, mem[2]);
        end
        @(negedge clk);
    endtask

    task automatic test_miscompare();
        int d;
        reset_model();
        flip_addr = 5;
        go();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(d);
        tests_run++;
        if (err_count !== 16'd1 || first_err_addr !== 22'd5 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL miscompare: err=%0d fea=%0d pass=%b want 1/5/0", err_count, first_err_addr, pass);
        end
        tests_run++;
        if (wr_cnt[0] != 1 || timeout !== 1'b0) begin
            tests_failed++; $display("FAIL busy_start_ignored: wr0=%0d to=%b want 1/0", wr_cnt[0], timeout);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int d;
        reset_model();
        drop_addr = 6;
        go();
        wait_done(d);
        tests_run++;
        if (timeout !== 1'b1 || pass !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_flag: to=%b pass=%b want 1/0", timeout, pass);
        end
        tests_run++;
        if (err_count !== 16'd1 || first_err_addr !== 22'd6) begin
            tests_failed++;
            $display("FAIL timeout_shift: err=%0d fea=%0d want 1/6", err_count, first_err_addr);
        end
        tests_run++;
        if ((d - last_rd_cyc) <= TMO || (d - last_rd_cyc) > TMO + 10) begin
            tests_failed++;
            $display("FAIL timeout_delay: %0d cycles want in (%0d..%0d]", d - last_rd_cyc, TMO, TMO + 10);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int d;
        bit seen;
        reset_model();
        go();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!az_rd_n) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (!seen || az_rd_n !== 1'b1 || busy !== 1'b0 || az_cs !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_read: seen=%b rd_n=%b busy=%b cs=%b want 1/1/0/0", seen, az_rd_n, busy, az_cs);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        reset_model();
        go();
        wait_done(d);
        tests_run++;
        if (pass !== 1'b1 || err_count !== 16'd0) begin
            tests_failed++; $display("FAIL restart: pass=%b err=%0d want 1/0", pass, err_count);
        end
        @(negedge clk);
    endtask

`ifndef SDRAM_TEST_LOOP_EN
    task automatic test_no_restart();
        int d;
        reset_model();
        @(negedge clk) start = 1'b1;
        wait_done(d);
        repeat (5) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || az_wr_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_restart: done=%b busy=%b wr_n=%b want 1/0/1", done, busy, az_wr_n);
        end
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL done_release: done=%b want 0", done);
        end
    endtask
`else
    task automatic test_loop();
        int          dcount;
        logic        prev;
        logic [15:0] w2;
        bit          got;
        reset_model();
        dcount = 0; prev = 1'b0; got = 1'b0; w2 = '0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 3000 && dcount < 3; i++) begin
            @(negedge clk);
            if (done && !prev) dcount++;
            if (dcount == 1 && !got && !done && !az_wr_n && az_addr == 22'd0) begin
                w2 = az_data; got = 1'b1;
            end
            prev = done;
        end
        start = 1'b0;
        tests_run++;
        if (dcount != 3 || pass !== 1'b1 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL loop_count: pulses=%0d pass=%b err=%0d want 3/1/0", dcount, pass, err_count);
        end
        tests_run++;
        if (w2 !== 16'h4B87) begin
            tests_failed++; $display("FAIL loop_seed: loop2 wdata=%h want 4b87", w2);
        end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wait_stall();
        test_miscompare();
        test_timeout();
        test_reset_mid_read();
`ifndef SDRAM_TEST_LOOP_EN
        test_no_restart();
`else
        test_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
